// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg
//   Shared definitions for the Tomasulo datapath: default bus geometry, the
//   "no producer" tag value and the station-index-to-tag mapping. Used by the
//   CDB arbiter, the register file and the reservation stations so that all
//   of them agree on what a tag means.
//   No ports (package).
package tomasulo_pkg;

  localparam int DEF_NUM_RS = 3;
  localparam int DEF_TAG_W  = 2;
  localparam int DEF_DATA_W = 16;

  // Tag 0 is reserved: a register or operand tagged 0 has no pending producer.
  localparam int unsigned TAG_NONE = 32'd0;

  // Station index i broadcasts tag i+1 so that tag 0 stays free for TAG_NONE.
  function automatic int unsigned tag_of(input int unsigned idx);
    return idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin picker. Selects the first set bit of
//   'eligible' at or above 'pointer', wrapping to the lowest set bit when
//   nothing at or above the pointer is set.
//   Ports:
//     eligible  in   NUM_RS  candidate vector
//     pointer   in   PTR_W   index with highest priority this cycle
//     winner    out  NUM_RS  one-hot winner (all zero when nothing eligible)
//     found     out  1       at least one candidate is eligible
module rr_priority_picker #(
  parameter int NUM_RS = 3,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_RS-1:0] eligible,
  input  logic [PTR_W-1:0]  pointer,
  output logic [NUM_RS-1:0] winner,
  output logic              found
);

  logic [NUM_RS-1:0] upper_s;
  logic [NUM_RS-1:0] pick_s;

  // Candidates at or above the pointer take precedence over wrapped ones.
  always_comb begin
    upper_s = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      upper_s[i] = eligible[i] & (PTR_W'(i) >= pointer);
    end
  end

  // Isolate the lowest set bit of the chosen half (x & -x).
  always_comb begin
    pick_s = (|upper_s) ? upper_s : eligible;
    winner = pick_s & (~pick_s + NUM_RS'(1));
    found  = |eligible;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter and driver for the Common Data Bus. Each cycle one
//   requesting station is chosen; one clock later its tag and result are
//   broadcast together with a one-cycle Ack pulse back to that station.
//   Ports:
//     Clock        in   1              posedge clock
//     Reset        in   1              synchronous, active-high
//     Stall        in   1              suppress new grants this cycle
//     Req          in   NUM_RS         station i holds a finished result
//     Data_in      in   NUM_RS*DATA_W  station i at [i*DATA_W +: DATA_W]
//     Ack          out  NUM_RS         one-hot pulse: station's result is on bus
//     CDB_valid    out  1              bus carries a broadcast
//     Qi_CDB       out  TAG_W          broadcasting tag (i+1), 0 when idle
//     CDB          out  DATA_W         broadcast result, 0 when idle
//     Grant_count  out  16             saturating broadcast count since reset
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_RS = DEF_NUM_RS,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Stall,
  input  logic [NUM_RS-1:0]        Req,
  input  logic [NUM_RS*DATA_W-1:0] Data_in,
  output logic [NUM_RS-1:0]        Ack,
  output logic                     CDB_valid,
  output logic [TAG_W-1:0]         Qi_CDB,
  output logic [DATA_W-1:0]        CDB,
  output logic [15:0]              Grant_count
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_RS-1:0] ack_r;
  logic              valid_r;
  logic [TAG_W-1:0]  tag_r;
  logic [DATA_W-1:0] cdb_r;
  logic [15:0]       count_r;
  logic [PTR_W-1:0]  pointer_r;

  logic [NUM_RS-1:0] eligible_s;
  logic [NUM_RS-1:0] winner_s;
  logic              found_s;
  logic              grant_s;
  logic [PTR_W-1:0]  win_idx_s;
  logic [TAG_W-1:0]  win_tag_s;
  logic [DATA_W-1:0] win_data_s;
  logic [PTR_W-1:0]  ptr_next_s;

  // A station's Req is still high during its own Ack cycle, so mask it out
  // to avoid granting the same result twice.
  always_comb begin
    eligible_s = Req & ~ack_r;
    grant_s    = found_s & ~Stall;
  end

  rr_priority_picker #(
    .NUM_RS (NUM_RS),
    .PTR_W  (PTR_W)
  ) u_picker (
    .eligible (eligible_s),
    .pointer  (pointer_r),
    .winner   (winner_s),
    .found    (found_s)
  );

  // One-hot to index/tag/data: AND-OR mux, the one-hot winner selects one lane.
  always_comb begin
    win_idx_s  = '0;
    win_tag_s  = '0;
    win_data_s = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      win_idx_s  = win_idx_s  | ({PTR_W{winner_s[i]}} & PTR_W'(i));
      win_tag_s  = win_tag_s  | ({TAG_W{winner_s[i]}} & TAG_W'(tag_of(i)));
      win_data_s = win_data_s | ({DATA_W{winner_s[i]}} & Data_in[i*DATA_W +: DATA_W]);
    end
  end

  // The station after the winner gets top priority next time.
  always_comb begin
    if (win_idx_s == PTR_W'(NUM_RS - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_idx_s + PTR_W'(1);
    end
  end

  // Bus output registers, round-robin pointer and broadcast counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ack_r     <= '0;
      valid_r   <= 1'b0;
      tag_r     <= TAG_W'(TAG_NONE);
      cdb_r     <= '0;
      count_r   <= 16'h0000;
      pointer_r <= '0;
    end else if (grant_s) begin
      ack_r     <= winner_s;
      valid_r   <= 1'b1;
      tag_r     <= win_tag_s;
      cdb_r     <= win_data_s;
      pointer_r <= ptr_next_s;
      if (count_r != 16'hFFFF) begin
        count_r <= count_r + 16'h0001;
      end else begin
        count_r <= count_r;
      end
    end else begin
      // Idle: bus returns to zero, pointer and count hold.
      ack_r     <= '0;
      valid_r   <= 1'b0;
      tag_r     <= TAG_W'(TAG_NONE);
      cdb_r     <= '0;
      count_r   <= count_r;
      pointer_r <= pointer_r;
    end
  end

  assign Ack         = ack_r;
  assign CDB_valid   = valid_r;
  assign Qi_CDB      = tag_r;
  assign CDB         = cdb_r;
  assign Grant_count = count_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed, table-driven bench for cdb_arbiter (3 stations, 2-bit tags,
//   16-bit data). Each row gives the inputs for one cycle and the outputs
//   expected right after the following rising edge.
module tb_cdb_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Stall;
  logic [2:0]  Req;
  logic [47:0] Data_in;
  logic [2:0]  Ack;
  logic        CDB_valid;
  logic [1:0]  Qi_CDB;
  logic [15:0] CDB;
  logic [15:0] Grant_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  req;
    logic [15:0] d0, d1, d2;
    logic [2:0]  ack;
    logic        valid;
    logic [1:0]  tag;
    logic [15:0] cdb;
    logic [15:0] cnt;
    string       name;
  } vec_t;

  vec_t tbl[$];

  cdb_arbiter #(.NUM_RS(3), .TAG_W(2), .DATA_W(16)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Stall       (Stall),
    .Req         (Req),
    .Data_in     (Data_in),
    .Ack         (Ack),
    .CDB_valid   (CDB_valid),
    .Qi_CDB      (Qi_CDB),
    .CDB         (CDB),
    .Grant_count (Grant_count)
  );

  always #5 Clock = ~Clock;

  task automatic add(input string name, input logic rst, input logic stall, input logic [2:0] req,
                     input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                     input logic [2:0] ack, input logic valid, input logic [1:0] tag,
                     input logic [15:0] cdb, input logic [15:0] cnt);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.req = req;
    v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.ack = ack; v.valid = valid; v.tag = tag; v.cdb = cdb; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    Reset   = v.rst;
    Stall   = v.stall;
    Req     = v.req;
    Data_in = {v.d2, v.d1, v.d0};
    @(posedge Clock);
    #1;
    checks++;
    if (Ack !== v.ack || CDB_valid !== v.valid || Qi_CDB !== v.tag ||
        CDB !== v.cdb || Grant_count !== v.cnt) begin
      errors++;
      $display("FAIL %s: got ack=%b valid=%b tag=%0d cdb=%h cnt=%0d, want ack=%b valid=%b tag=%0d cdb=%h cnt=%0d",
               v.name, Ack, CDB_valid, Qi_CDB, CDB, Grant_count,
               v.ack, v.valid, v.tag, v.cdb, v.cnt);
    end
  endtask

  initial begin
    vec_t v;
    Reset = 1'b1; Stall = 1'b0; Req = 3'b000; Data_in = '0;

    //   name           rst  stl  req     d0        d1        d2        ack     v     tag   cdb       cnt
    // Reset held two cycles with all requesting
    add("reset0",      1'b1,1'b0,3'b111,16'h0011,16'h0022,16'h0033, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    add("reset1",      1'b1,1'b0,3'b111,16'h0011,16'h0022,16'h0033, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    // Single requester (station 1), drops Req after seeing Ack
    add("single_gnt",  1'b0,1'b0,3'b010,16'h0000,16'h00A5,16'h0000, 3'b010,1'b1,2'd2,16'h00A5,16'd1);
    add("single_mask", 1'b0,1'b0,3'b010,16'h0000,16'h00A5,16'h0000, 3'b000,1'b0,2'd0,16'h0000,16'd1);
    add("re_reset",    1'b1,1'b0,3'b000,16'h0000,16'h0000,16'h0000, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    // Full contention from pointer 0
    add("full_t1",     1'b0,1'b0,3'b111,16'h0011,16'h0022,16'h0033, 3'b001,1'b1,2'd1,16'h0011,16'd1);
    add("full_t2",     1'b0,1'b0,3'b111,16'h0011,16'h0022,16'h0033, 3'b010,1'b1,2'd2,16'h0022,16'd2);
    add("full_t3",     1'b0,1'b0,3'b110,16'h0011,16'h0022,16'h0033, 3'b100,1'b1,2'd3,16'h0033,16'd3);
    add("full_idle",   1'b0,1'b0,3'b100,16'h0011,16'h0022,16'h0033, 3'b000,1'b0,2'd0,16'h0000,16'd3);
    add("idle",        1'b0,1'b0,3'b000,16'h0011,16'h0022,16'h0033, 3'b000,1'b0,2'd0,16'h0000,16'd3);
    // Masking: station 0 alone keeps Req high after Ack
    add("mask_gnt",    1'b0,1'b0,3'b001,16'h0044,16'h0000,16'h0000, 3'b001,1'b1,2'd1,16'h0044,16'd4);
    add("mask_block",  1'b0,1'b0,3'b001,16'h0044,16'h0000,16'h0000, 3'b000,1'b0,2'd0,16'h0000,16'd4);
    add("mask_regnt",  1'b0,1'b0,3'b001,16'h0044,16'h0000,16'h0000, 3'b001,1'b1,2'd1,16'h0044,16'd5);
    add("mask_block2", 1'b0,1'b0,3'b001,16'h0044,16'h0000,16'h0000, 3'b000,1'b0,2'd0,16'h0000,16'd5);
    add("re_reset2",   1'b1,1'b0,3'b000,16'h0000,16'h0000,16'h0000, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    // Stall for three cycles with stations 0 and 2 waiting
    add("stall0",      1'b0,1'b1,3'b101,16'h0055,16'h0000,16'h0077, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    add("stall1",      1'b0,1'b1,3'b101,16'h0055,16'h0000,16'h0077, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    add("stall2",      1'b0,1'b1,3'b101,16'h0055,16'h0000,16'h0077, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    add("unstall_t1",  1'b0,1'b0,3'b101,16'h0055,16'h0000,16'h0077, 3'b001,1'b1,2'd1,16'h0055,16'd1);
    // Station 0's data changes while masked; only the winner is sampled
    add("unstall_t3",  1'b0,1'b0,3'b101,16'hFFFF,16'h0000,16'h0077, 3'b100,1'b1,2'd3,16'h0077,16'd2);
    add("unstall_idl", 1'b0,1'b0,3'b100,16'hFFFF,16'h0000,16'h0077, 3'b000,1'b0,2'd0,16'h0000,16'd2);
    add("idle2",       1'b0,1'b0,3'b000,16'h0000,16'h0000,16'h0000, 3'b000,1'b0,2'd0,16'h0000,16'd2);
    // Reset while Ack=100 is visible
    add("pre_rst_t2",  1'b0,1'b0,3'b010,16'h0000,16'h0088,16'h0000, 3'b010,1'b1,2'd2,16'h0088,16'd3);
    add("pre_rst_t3",  1'b0,1'b0,3'b110,16'h0000,16'h0088,16'h0099, 3'b100,1'b1,2'd3,16'h0099,16'd4);
    add("mid_reset",   1'b1,1'b0,3'b111,16'h0011,16'h0022,16'h0033, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    add("post_rst_t1", 1'b0,1'b0,3'b111,16'h0011,16'h0022,16'h0033, 3'b001,1'b1,2'd1,16'h0011,16'd1);
    // Pointer is 1 here; reset must put it back to 0
    add("ptr1_idle",   1'b0,1'b0,3'b000,16'h0000,16'h0000,16'h0000, 3'b000,1'b0,2'd0,16'h0000,16'd1);
    add("ptr_reset",   1'b1,1'b0,3'b010,16'h0000,16'h0000,16'h0000, 3'b000,1'b0,2'd0,16'h0000,16'd0);
    add("ptr0_gnt",    1'b0,1'b0,3'b101,16'h00C0,16'h0000,16'h00C2, 3'b001,1'b1,2'd1,16'h00C0,16'd1);
    add("ptr0_idle",   1'b0,1'b0,3'b000,16'h00C0,16'h0000,16'h00C2, 3'b000,1'b0,2'd0,16'h0000,16'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
    end

    // Hand sequence: pointer (now 1) must survive a stall.
    v = '{rst:1'b0, stall:1'b0, req:3'b001, d0:16'h00D0, d1:16'h0000, d2:16'h00D2,
          ack:3'b001, valid:1'b1, tag:2'd1, cdb:16'h00D0, cnt:16'd2, name:"hs_gnt0"};
    run_vec(v);
    v.stall = 1'b1; v.req = 3'b101; v.ack = 3'b000; v.valid = 1'b0; v.tag = 2'd0; v.cdb = 16'h0000;
    v.name = "hs_stall_a"; run_vec(v);
    v.name = "hs_stall_b"; run_vec(v);
    // Pointer is 1 after granting station 0, so station 2 wins over station 0.
    v.stall = 1'b0; v.ack = 3'b100; v.valid = 1'b1; v.tag = 2'd3; v.cdb = 16'h00D2; v.cnt = 16'd3;
    v.name = "hs_resume"; run_vec(v);

    // Hand sequence: all three held high, grants rotate 0,1,2,0,1,2 back to back.
    v.req = 3'b111; v.d0 = 16'h0011; v.d1 = 16'h0022; v.d2 = 16'h0033; v.valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      v.ack  = 3'b001 << (k % 3);
      v.tag  = 2'((k % 3) + 1);
      v.cdb  = (k % 3 == 0) ? 16'h0011 : ((k % 3 == 1) ? 16'h0022 : 16'h0033);
      v.cnt  = 16'(4 + k);
      v.name = "hs_rotate";
      run_vec(v);
    end
    v.req = 3'b000; v.ack = 3'b000; v.valid = 1'b0; v.tag = 2'd0; v.cdb = 16'h0000; v.cnt = 16'd9;
    v.name = "hs_final_idle"; run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
